// File: rtl/int_event_tracker.sv
// int_event_tracker: latches debounced interrupt edges, tracks ack/overrun/timeout, counts events, measures pulse width
module int_event_tracker #(
  parameter int PARM_CNT_BITS       = 8,
  parameter int PARM_WIDTH_BITS     = 16,
  parameter int PARM_TIMEOUT_CYCLES = 2000000
) (
  input  logic                       i_clk_20mhz,
  input  logic                       i_rst_20mhz,
  input  logic                       i_int_deb,
  input  logic                       i_ack,
  output logic                       o_int_pending,
  output logic                       o_int_rise_pulse,
  output logic                       o_int_overrun,
  output logic                       o_int_timeout,
  output logic [PARM_CNT_BITS-1:0]   o_event_count,
  output logic [PARM_WIDTH_BITS-1:0] o_last_width
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PEND = 2'd1, ST_TOUT = 2'd2} state_t;
  localparam logic [21:0] TIMER_LAST = 22'(PARM_TIMEOUT_CYCLES - 1);
  localparam logic [PARM_CNT_BITS-1:0] CNT_ONE = {{(PARM_CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [PARM_WIDTH_BITS-1:0] WIDTH_ONE = {{(PARM_WIDTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [PARM_WIDTH_BITS-1:0] WIDTH_MAX = '1;
  state_t state, state_n;
  logic [21:0] timer, timer_n;
  logic overrun_n, timeout_n;
  logic s_int_prev, rise, fall;
  logic [PARM_WIDTH_BITS-1:0] width_cnt, width_inc;
  assign rise = i_int_deb & ~s_int_prev;
  assign fall = ~i_int_deb & s_int_prev;
  assign width_inc = (width_cnt == WIDTH_MAX) ? WIDTH_MAX : width_cnt + WIDTH_ONE;
  // FSM state register
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) state <= ST_IDLE;
    else state <= state_n;
  end
  // next state, ack timer and sticky flags; an ack always wins and restarts on a coincident rise
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    overrun_n = o_int_overrun;
    timeout_n = o_int_timeout;
    case (state)
      ST_IDLE: begin
        state_n = rise ? ST_PEND : ST_IDLE;
        timer_n = rise ? '0 : timer;
      end
      ST_PEND, ST_TOUT: begin
        if (i_ack) begin
          state_n   = rise ? ST_PEND : ST_IDLE;
          timer_n   = '0;
          overrun_n = 1'b0;
          timeout_n = 1'b0;
        end else begin
          overrun_n = o_int_overrun | rise;
          if (state == ST_PEND) begin
            timer_n   = timer + 22'd1;
            state_n   = (timer == TIMER_LAST) ? ST_TOUT : ST_PEND;
            timeout_n = o_int_timeout | (timer == TIMER_LAST);
          end
        end
      end
      default: begin
        state_n   = ST_IDLE;
        timer_n   = '0;
        overrun_n = 1'b0;
        timeout_n = 1'b0;
      end
    endcase
  end
  // registered event outputs, all updated on the edge that sees the rise
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      timer            <= '0;
      o_int_pending    <= 1'b0;
      o_int_rise_pulse <= 1'b0;
      o_int_overrun    <= 1'b0;
      o_int_timeout    <= 1'b0;
      o_event_count    <= '0;
    end else begin
      timer            <= timer_n;
      o_int_pending    <= state_n != ST_IDLE;
      o_int_rise_pulse <= rise;
      o_int_overrun    <= overrun_n;
      o_int_timeout    <= timeout_n;
      o_event_count    <= rise ? o_event_count + CNT_ONE : o_event_count;
    end
  end
  // input history and saturating high-pulse width measurement
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      s_int_prev   <= 1'b0;
      width_cnt    <= '0;
      o_last_width <= '0;
    end else begin
      s_int_prev   <= i_int_deb;
      width_cnt    <= rise ? '0 : (i_int_deb ? width_inc : width_cnt);
      o_last_width <= fall ? width_inc : o_last_width;
    end
  end
endmodule

// File: tb/tb_int_event_tracker.sv
// tb_int_event_tracker: scenario tasks with scoreboard queues for event count and pulse width
`timescale 1ns/1ps
module tb_int_event_tracker;
  logic i_clk_20mhz = 1'b0;
  logic i_rst_20mhz = 1'b1;
  logic i_int_deb = 1'b0;
  logic i_ack = 1'b0;
  logic o_int_pending, o_int_rise_pulse, o_int_overrun, o_int_timeout;
  logic [7:0] o_event_count;
  logic [15:0] o_last_width;
  int checks = 0;
  int passes = 0;
  int m_count = 0;
  logic [7:0] exp_cnt_q[$];
  logic [15:0] exp_w_q[$];
  logic [7:0] ec;
  logic [15:0] ew;
  bit seen;

  int_event_tracker #(.PARM_CNT_BITS(8), .PARM_WIDTH_BITS(16), .PARM_TIMEOUT_CYCLES(50)) dut (
    .i_clk_20mhz(i_clk_20mhz), .i_rst_20mhz(i_rst_20mhz), .i_int_deb(i_int_deb), .i_ack(i_ack),
    .o_int_pending(o_int_pending), .o_int_rise_pulse(o_int_rise_pulse), .o_int_overrun(o_int_overrun),
    .o_int_timeout(o_int_timeout), .o_event_count(o_event_count), .o_last_width(o_last_width));

  always #5 i_clk_20mhz = ~i_clk_20mhz;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk_20mhz);
    #1;
  endtask

  task automatic wait_rise(output bit s);
    s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (o_int_rise_pulse) begin
        s = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic drive_rise();
    i_int_deb = 1'b1;
    m_count++;
    exp_cnt_q.push_back(8'(m_count));
    cyc(1);
  endtask

  task automatic do_ack();
    i_ack = 1'b1;
    cyc(1);
    i_ack = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_20mhz = 1'b1; i_int_deb = 1'b0; i_ack = 1'b0;
    cyc(3);
    checks++;
    if ({o_int_pending, o_int_rise_pulse, o_int_overrun, o_int_timeout, o_event_count, o_last_width} !== 28'h0)
      $display("FAIL reset_outputs: got %0h expected 0", {o_int_pending, o_int_rise_pulse, o_int_overrun, o_int_timeout, o_event_count, o_last_width});
    else passes++;
    i_rst_20mhz = 1'b0;
    cyc(2);
    checks++;
    if ({o_int_pending, o_int_rise_pulse, o_event_count} !== 10'h0)
      $display("FAIL idle_after_reset: got %0h expected 0", {o_int_pending, o_int_rise_pulse, o_event_count});
    else passes++;
  endtask

  task automatic test_single_pulse();
    drive_rise();
    wait_rise(seen);
    checks++;
    if (!seen) $display("FAIL first_rise_pulse: got 0 expected 1"); else passes++;
    ec = exp_cnt_q.pop_front();
    checks++;
    if (o_event_count !== ec) $display("FAIL first_count: got %0h expected %0h", o_event_count, ec); else passes++;
    checks++;
    if (o_int_pending !== 1'b1) $display("FAIL first_pending: got %0b expected 1", o_int_pending); else passes++;
    cyc(1);
    checks++;
    if (o_int_rise_pulse !== 1'b0) $display("FAIL pulse_one_cycle: got %0b expected 0", o_int_rise_pulse); else passes++;
    cyc(38);
    checks++;
    if (o_last_width !== 16'd0) $display("FAIL width_while_high: got %0d expected 0", o_last_width); else passes++;
    i_int_deb = 1'b0;
    exp_w_q.push_back(16'd40);
    cyc(1);
    ew = exp_w_q.pop_front();
    checks++;
    if (o_last_width !== ew) $display("FAIL width_40: got %0d expected %0d", o_last_width, ew); else passes++;
    checks++;
    if (o_event_count !== 8'(m_count)) $display("FAIL level_single_count: got %0h expected %0h", o_event_count, 8'(m_count)); else passes++;
  endtask

  task automatic test_ack();
    do_ack();
    checks++;
    if ({o_int_pending, o_int_overrun, o_int_timeout} !== 3'b000)
      $display("FAIL ack_clears: got %03b expected 000", {o_int_pending, o_int_overrun, o_int_timeout});
    else passes++;
    do_ack();
    cyc(1);
    checks++;
    if ({o_int_pending, o_event_count, o_last_width} !== {1'b0, 8'(m_count), 16'd40})
      $display("FAIL idle_ack_ignored: got %0h expected %0h", {o_int_pending, o_event_count, o_last_width}, {1'b0, 8'(m_count), 16'd40});
    else passes++;
  endtask

  task automatic test_overrun();
    drive_rise();
    wait_rise(seen);
    ec = exp_cnt_q.pop_front();
    checks++;
    if (!seen || o_event_count !== ec) $display("FAIL ovr_count_a: got %0h expected %0h", o_event_count, ec); else passes++;
    cyc(4);
    i_int_deb = 1'b0;
    cyc(20);
    checks++;
    if ({o_int_pending, o_int_overrun} !== 2'b10)
      $display("FAIL ovr_before_second: got %02b expected 10", {o_int_pending, o_int_overrun});
    else passes++;
    drive_rise();
    wait_rise(seen);
    ec = exp_cnt_q.pop_front();
    checks++;
    if (!seen || o_event_count !== ec) $display("FAIL ovr_count_b: got %0h expected %0h", o_event_count, ec); else passes++;
    checks++;
    if ({o_int_pending, o_int_overrun} !== 2'b11)
      $display("FAIL ovr_set: got %02b expected 11", {o_int_pending, o_int_overrun});
    else passes++;
    i_int_deb = 1'b0;
    do_ack();
    checks++;
    if ({o_int_pending, o_int_overrun} !== 2'b00)
      $display("FAIL ovr_ack_clears: got %02b expected 00", {o_int_pending, o_int_overrun});
    else passes++;
  endtask

  task automatic test_timeout();
    drive_rise();
    wait_rise(seen);
    ec = exp_cnt_q.pop_front();
    checks++;
    if (!seen || o_event_count !== ec) $display("FAIL tout_count: got %0h expected %0h", o_event_count, ec); else passes++;
    i_int_deb = 1'b0;
    cyc(49);
    checks++;
    if (o_int_timeout !== 1'b0) $display("FAIL tout_early: got %0b expected 0", o_int_timeout); else passes++;
    cyc(1);
    checks++;
    if ({o_int_pending, o_int_timeout} !== 2'b11)
      $display("FAIL tout_at_50: got %02b expected 11", {o_int_pending, o_int_timeout});
    else passes++;
    cyc(3);
    drive_rise();
    wait_rise(seen);
    ec = exp_cnt_q.pop_front();
    checks++;
    if ({o_int_pending, o_int_overrun, o_int_timeout, o_event_count} !== {3'b111, ec})
      $display("FAIL tout_rise_overrun: got %0h expected %0h", {o_int_pending, o_int_overrun, o_int_timeout, o_event_count}, {3'b111, ec});
    else passes++;
    i_int_deb = 1'b0;
    do_ack();
    checks++;
    if ({o_int_pending, o_int_overrun, o_int_timeout} !== 3'b000)
      $display("FAIL tout_ack_clears: got %03b expected 000", {o_int_pending, o_int_overrun, o_int_timeout});
    else passes++;
  endtask

  task automatic test_ack_rise();
    drive_rise();
    wait_rise(seen);
    ec = exp_cnt_q.pop_front();
    checks++;
    if (!seen || o_event_count !== ec) $display("FAIL ackrise_count_a: got %0h expected %0h", o_event_count, ec); else passes++;
    i_int_deb = 1'b0;
    cyc(10);
    i_ack = 1'b1;
    drive_rise();
    i_ack = 1'b0;
    wait_rise(seen);
    ec = exp_cnt_q.pop_front();
    checks++;
    if ({seen, o_int_pending, o_int_overrun, o_event_count} !== {3'b110, ec})
      $display("FAIL ackrise_state: got %0h expected %0h", {seen, o_int_pending, o_int_overrun, o_event_count}, {3'b110, ec});
    else passes++;
    i_int_deb = 1'b0;
    cyc(49);
    checks++;
    if (o_int_timeout !== 1'b0) $display("FAIL ackrise_timer_restart: got %0b expected 0", o_int_timeout); else passes++;
    cyc(1);
    checks++;
    if (o_int_timeout !== 1'b1) $display("FAIL ackrise_tout_at_50: got %0b expected 1", o_int_timeout); else passes++;
    do_ack();
    checks++;
    if ({o_int_pending, o_int_timeout} !== 2'b00)
      $display("FAIL ackrise_final_ack: got %02b expected 00", {o_int_pending, o_int_timeout});
    else passes++;
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - (m_count % 256);
    for (int i = 0; i < n; i++) begin
      drive_rise();
      wait_rise(seen);
      ec = exp_cnt_q.pop_front();
      checks++;
      if (!seen || o_event_count !== ec) $display("FAIL wrap_count_%0d: got %0h expected %0h", i, o_event_count, ec); else passes++;
      i_int_deb = 1'b0;
      cyc(1);
    end
    checks++;
    if (o_event_count !== 8'h00) $display("FAIL wrap_to_zero: got %0h expected 00", o_event_count); else passes++;
    checks++;
    if (o_last_width !== 16'd1) $display("FAIL width_1: got %0d expected 1", o_last_width); else passes++;
    do_ack();
  endtask

  task automatic test_saturate();
    drive_rise();
    wait_rise(seen);
    ec = exp_cnt_q.pop_front();
    checks++;
    if (!seen || o_event_count !== ec) $display("FAIL sat_count: got %0h expected %0h", o_event_count, ec); else passes++;
    cyc(69999);
    checks++;
    if (o_last_width !== 16'd1) $display("FAIL sat_hold_while_high: got %0d expected 1", o_last_width); else passes++;
    i_int_deb = 1'b0;
    exp_w_q.push_back(16'hFFFF);
    cyc(1);
    ew = exp_w_q.pop_front();
    checks++;
    if (o_last_width !== ew) $display("FAIL sat_width: got %0h expected %0h", o_last_width, ew); else passes++;
    do_ack();
  endtask

  task automatic test_reset_mid();
    drive_rise();
    wait_rise(seen);
    void'(exp_cnt_q.pop_front());
    i_int_deb = 1'b0;
    cyc(3);
    drive_rise();
    wait_rise(seen);
    void'(exp_cnt_q.pop_front());
    checks++;
    if (o_int_overrun !== 1'b1) $display("FAIL rstmid_precond: got %0b expected 1", o_int_overrun); else passes++;
    i_rst_20mhz = 1'b1;
    cyc(1);
    checks++;
    if ({o_int_pending, o_int_rise_pulse, o_int_overrun, o_int_timeout, o_event_count, o_last_width} !== 28'h0)
      $display("FAIL rstmid_outputs: got %0h expected 0", {o_int_pending, o_int_rise_pulse, o_int_overrun, o_int_timeout, o_event_count, o_last_width});
    else passes++;
    cyc(1);
    i_rst_20mhz = 1'b0;
    m_count = 0;
    drive_rise();
    wait_rise(seen);
    ec = exp_cnt_q.pop_front();
    checks++;
    if ({seen, o_int_pending, o_event_count} !== {2'b11, ec})
      $display("FAIL rise_after_reset: got %0h expected %0h", {seen, o_int_pending, o_event_count}, {2'b11, ec});
    else passes++;
    i_int_deb = 1'b0;
    do_ack();
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_ack();
    test_overrun();
    test_timeout();
    test_ack_rise();
    test_wrap();
    test_saturate();
    test_reset_mid();
    checks++;
    if (exp_cnt_q.size() + exp_w_q.size() !== 0)
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_cnt_q.size() + exp_w_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
